divider_arbiter: RTL and testbench
==================================

// Module: divider_arbiter
// PURPOSE
//  Shares one N-bit restoring Divider between REQUESTERS clients. Arbitrates round-robin, latches the
//  winner's operands and holds them stable on the divider for the whole operation. Sequences the
//  divider's start/finished protocol, short-circuits divide-by-zero and returns tagged results.
//  Sits between client FSMs and the single Divider instance.
// PARAMETERS
//  N           8   operand width; must match the attached Divider
//  REQUESTERS  4   number of clients (>=2)
//  TIMEOUT     N+2 cycles after o_div_start before i_div_finished is declared missing
// PORTS
//  i_clock             in   1       clock
//  i_reset             in   1       synchronous, active-high reset; also routed to the Divider
//  i_request           in   R       per-client request level; held with operands until granted
//  i_dividend          in   R*N     client r operand at [r*N +: N]
//  i_divisor           in   R*N     client r operand at [r*N +: N]
//  o_grant             out  R       one-hot, 1-cycle pulse; operands captured on that edge
//  o_valid             out  R       one-hot, 1-cycle pulse; result for that client on o_quotient/o_remainder
//  o_quotient          out  N       registered result
//  o_remainder         out  N       registered result
//  o_divide_by_zero    out  1       qualifies o_valid: divisor was 0
//  o_error             out  1       1-cycle pulse on timeout; o_valid of owner pulses with it
//  o_busy              out  1       high in every state except IDLE
//  o_div_start         out  1       to Divider i_start, 1-cycle pulse
//  o_div_dividend      out  N       to Divider, held from START until DONE
//  o_div_divisor       out  N       to Divider, held from START until DONE (Divider reloads it every cycle)
//  i_div_finished      in   1       from Divider
//  i_div_quotient      in   N       from Divider, valid only while i_div_finished
//  i_div_remainder     in   N       from Divider, valid only while i_div_finished
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs and operand/result regs 0.
//  IDLE: if any i_request, winner = first requester at or after rr pointer (wrapping).
//   o_grant[winner] is combinational in IDLE; operands and owner index latch on that edge.
//   Next state: ZERO if latched divisor == 0, else START. No request: stay IDLE.
//  START: o_div_start=1 for exactly one cycle. Timeout counter cleared. -> WAIT.
//  WAIT: count cycles. On i_div_finished, capture quotient/remainder -> DONE.
//   If count reaches TIMEOUT without finished: o_error=1, result 0 -> DONE.
//   Nominal finish: N cycles after the START cycle.
//  ZERO: Divider not started. Result quotient = all ones, remainder = dividend, flag=1 -> DONE.
//  DONE: o_valid[owner]=1 one cycle, outputs hold until the next DONE.
//   rr pointer <= owner+1 mod R. -> IDLE.
//  Latency (grant edge to o_valid): N+2 cycles normal; 2 cycles divide-by-zero.
//   Throughput: one op per N+3 cycles; no grant issued outside IDLE.
//  Grant ordering:
//   Simultaneous requests: strict rotation.
//   A requester dropping i_request before grant is legal and gets no grant.
//   Re-request by the just-served client yields to other pending clients.
//  o_div_dividend/o_div_divisor change only on grant edges, never during START/WAIT.
//  Reset mid-operation (any state): immediate return to IDLE, no o_valid/o_error, pointer 0.
//   Clients must re-request.
//  Width: quotient/remainder N bits, no overflow possible; owner index $clog2(R) bits.
// STRUCTURE
//  Package divider_pkg:
//   state enum {IDLE, START, WAIT, ZERO, DONE}
//   localparam TIMEOUT width $clog2(TIMEOUT+1)
//   shared default N
//  Sub-module round_robin_arbiter #(R): req, pointer -> one-hot grant + index, purely combinational.
//  FSM, operand/result registers and timeout counter live in divider_arbiter. Divider is instantiated outside.
// TESTING
//  Bench uses a real Divider instance, N=8, R=4.
//  Single op: req0, 200/7 -> grant0 in same cycle; o_valid[0] 10 cycles later; q=28, r=4, flags 0.
//  Contention: req0..3 together, ptr 0 -> grants 0,1,2,3 in order, each 11 cycles apart; results tagged correctly.
//  Divide by zero: req2, 55/0 -> o_div_start never asserts; o_valid[2] 2 cycles after grant; q=255, r=55, dbz=1.
//  Fairness: req1 held continuously with req3 -> grants alternate 1,3,1,3.
//  Timeout: stub i_div_finished=0, req0 -> o_error and o_valid[0] at TIMEOUT+2 after grant; result 0; back to IDLE.
//  Mid-op reset: reset 4 cycles into WAIT -> outputs 0, IDLE next cycle; a fresh req3 is granted and completes normally.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the divider arbiter slice.
package divider_pkg;

  // Operand width of the shared Divider
  localparam int DIV_N = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t WAIT  = 3'd2;
  localparam state_t ZERO  = 3'd3;
  localparam state_t DONE  = 3'd4;

  // Width of a counter that can hold values 0..timeout
  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// Client-side bus of the divider arbiter: requests with operands in, grants and tagged results out.
interface divider_arbiter_if
  import divider_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int R = 4
);
  logic [R-1:0]   i_request;
  logic [R*N-1:0] i_dividend;
  logic [R*N-1:0] i_divisor;
  logic [R-1:0]   o_grant;
  logic [R-1:0]   o_valid;
  logic [N-1:0]   o_quotient;
  logic [N-1:0]   o_remainder;
  logic           o_divide_by_zero;
  logic           o_error;

  // Arbiter side
  modport slave (
    input  i_request, i_dividend, i_divisor,
    output o_grant, o_valid, o_quotient, o_remainder, o_divide_by_zero, o_error
  );

  // Client side
  modport master (
    output i_request, i_dividend, i_divisor,
    input  o_grant, o_valid, o_quotient, o_remainder, o_divide_by_zero, o_error
  );
endinterface

// File: rtl/divider.sv
// Restoring divider: one quotient bit per cycle, first bit computed on the start edge,
// so o_finished pulses N-1 edges after the start edge with the result held afterwards.
module divider
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_finished,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt;
  logic [N-1:0]  in_rem, in_quo, nxt_rem, nxt_quo;
  logic [N:0]    shifted, diff;

  // One restoring step; a start seeds it with a zero remainder and the fresh dividend
  always_comb begin
    in_rem  = i_start ? '0 : o_remainder;
    in_quo  = i_start ? i_dividend : o_quotient;
    shifted = {in_rem, in_quo[N-1]};
    diff    = shifted - {1'b0, i_divisor};
    nxt_quo = {in_quo[N-2:0], 1'b0};
    nxt_rem = shifted[N-1:0];
    if (shifted >= {1'b0, i_divisor}) begin
      nxt_quo[0] = 1'b1;
      nxt_rem    = diff[N-1:0];
    end
  end

  // Step counter and working registers; the divisor is re-read every cycle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt         <= '0;
      o_finished  <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      o_finished <= 1'b0;
      if (i_start) begin
        o_quotient  <= nxt_quo;
        o_remainder <= nxt_rem;
        cnt         <= CW'(N - 1);
      end else if (cnt != '0) begin
        o_quotient  <= nxt_quo;
        o_remainder <= nxt_rem;
        cnt         <= cnt - 1'b1;
        o_finished  <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/divider_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module round_robin_arbiter #(
  parameter int R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] ptr,
  output logic [R-1:0]         grant,
  output logic [$clog2(R)-1:0] idx
);
  localparam int IW = $clog2(R);

  // Scan outward from the pointer and keep the first hit
  always_comb begin
    int  c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < R; k++) begin
      c = (int'(ptr) + k) % R;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one Divider between REQUESTERS clients: round-robin grant, operand capture,
// start/finished sequencing with timeout, divide-by-zero bypass and tagged results.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int N          = DIV_N,
  parameter int REQUESTERS = 4,
  parameter int TIMEOUT    = N + 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  divider_arbiter_if.slave    bus,
  output logic                o_busy,
  output logic                o_div_start,
  output logic [N-1:0]        o_div_dividend,
  output logic [N-1:0]        o_div_divisor,
  input  logic                i_div_finished,
  input  logic [N-1:0]        i_div_quotient,
  input  logic [N-1:0]        i_div_remainder
);
  localparam int IW = $clog2(REQUESTERS);
  localparam int TW = tmo_width(TIMEOUT);

  state_t                 state;
  logic [IW-1:0]          ptr, owner, arb_idx;
  logic [REQUESTERS-1:0]  arb_grant;
  logic [TW-1:0]          tcnt;
  logic [N-1:0]           quo_q, rem_q, sel_dvd, sel_dvs;
  logic                   dbz_q, err_q;

  round_robin_arbiter #(.R(REQUESTERS)) u_arb (
    .req   (bus.i_request),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign sel_dvd = bus.i_dividend[arb_idx*N +: N];
  assign sel_dvs = bus.i_divisor[arb_idx*N +: N];

  // Grants only exist while idle; start is a single-cycle state
  assign bus.o_grant          = (state == IDLE) ? arb_grant : '0;
  assign o_div_start          = (state == START);
  assign o_busy               = (state != IDLE);
  assign bus.o_quotient       = quo_q;
  assign bus.o_remainder      = rem_q;
  assign bus.o_divide_by_zero = dbz_q;
  assign bus.o_error          = err_q && (state == DONE);

  // Result tag: owner's valid bit for the single DONE cycle
  always_comb begin
    bus.o_valid = '0;
    if (state == DONE) bus.o_valid[owner] = 1'b1;
  end

  // Main FSM with operand, result and timeout registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      o_div_dividend <= '0;
      o_div_divisor  <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      dbz_q          <= 1'b0;
      err_q          <= 1'b0;
      tcnt           <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.i_request) begin
          owner          <= arb_idx;
          o_div_dividend <= sel_dvd;
          o_div_divisor  <= sel_dvs;
          state          <= (sel_dvs == '0) ? ZERO : START;
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (i_div_finished) begin
            quo_q <= i_div_quotient;
            rem_q <= i_div_remainder;
            dbz_q <= 1'b0;
            err_q <= 1'b0;
            state <= DONE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Divider never answered: report a zero result flagged as error
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ZERO: begin
          quo_q <= '1;
          rem_q <= o_div_dividend;
          dbz_q <= 1'b1;
          err_q <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          ptr   <= (owner == IW'(REQUESTERS - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
module tb_divider_arbiter;
  localparam int N = 8, R = 4, T = N + 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         busy, dstart, dfin_raw, dfin;
  logic [N-1:0] ddvd, ddvs, dq, dr;
  bit           stub = 1'b0;
  assign dfin = stub ? 1'b0 : dfin_raw;

  divider_arbiter_if #(.N(N), .R(R)) dif();

  divider_arbiter #(.N(N), .REQUESTERS(R), .TIMEOUT(T)) dut (
    .i_clock(clk), .i_reset(rst), .bus(dif),
    .o_busy(busy), .o_div_start(dstart),
    .o_div_dividend(ddvd), .o_div_divisor(ddvs),
    .i_div_finished(dfin), .i_div_quotient(dq), .i_div_remainder(dr)
  );

  divider #(.N(N)) u_div (
    .i_clock(clk), .i_reset(rst), .i_start(dstart),
    .i_dividend(ddvd), .i_divisor(ddvs),
    .o_finished(dfin_raw), .o_quotient(dq), .o_remainder(dr)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model: pending requests with their operands and the rotation pointer
  bit         req_m [R];
  logic [7:0] a_m [R], b_m [R];
  int         rr_left [R];
  int         ptr_m = 0;
  int         gseq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic raise(input int c, input logic [7:0] a, input logic [7:0] b);
    req_m[c] = 1'b1; a_m[c] = a; b_m[c] = b;
    dif.i_request[c] = 1'b1;
    dif.i_dividend[c*N +: N] = a;
    dif.i_divisor[c*N +: N] = b;
  endtask

  task automatic clear_all();
    for (int k = 0; k < R; k++) begin req_m[k] = 1'b0; rr_left[k] = 0; end
    dif.i_request = '0;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < R; k++) p |= req_m[k];
    return p;
  endfunction

  function automatic int predict();
    for (int k = 0; k < R; k++) if (req_m[(ptr_m + k) % R]) return (ptr_m + k) % R;
    return -1;
  endfunction

  // Serve every pending request, checking each grant/result against the model
  task automatic serve(input int ghost);
    int prev = -1, pgap = 0;
    while (pending()) begin
      int w, t, gi, lat, starts, elat;
      bit stable, busy_ok, edbz, eerr;
      logic [7:0] a, b, eq, er;
      w = predict();
      #1; t = 0;
      while (dif.o_grant == '0 && t < 40) begin step(); t++; end
      if (dif.o_grant == '0) begin chk("grant_timeout", 0, 1); clear_all(); return; end
      gi = -1;
      for (int k = 0; k < R; k++) if (dif.o_grant[k]) gi = k;
      chk("grant_idx", gi, w);
      chk("grant_onehot", 32'($onehot(dif.o_grant)), 1);
      if (prev >= 0) chk("grant_gap", cyc - prev, pgap);
      prev = cyc; gseq.push_back(gi);
      a = a_m[w]; b = b_m[w];
      if (b == 0)    begin eq = 8'hff; er = a; edbz = 1; eerr = 0; elat = 2; end
      else if (stub) begin eq = 0; er = 0; edbz = 0; eerr = 1; elat = T + 2; end
      else           begin eq = a / b; er = a % b; edbz = 0; eerr = 0; elat = N + 2; end
      step();
      req_m[w] = 1'b0; dif.i_request[w] = 1'b0;
      lat = 1; starts = 0; stable = 1; busy_ok = 1;
      while (dif.o_valid == '0 && lat < 60) begin
        if (dif.o_grant != '0 || !busy) busy_ok = 0;
        if (dstart) starts++;
        if (ddvd !== a || ddvs !== b) stable = 0;
        if (ghost >= 0 && lat == 3) dif.i_request[ghost] = 1'b1;
        if (ghost >= 0 && lat == 6) dif.i_request[ghost] = 1'b0;
        step(); lat++;
      end
      if (dif.o_valid == '0) begin chk("valid_timeout", 0, 1); clear_all(); return; end
      chk("latency", lat, elat);
      chk("valid_tag", 32'(dif.o_valid), 32'(1) << w);
      chk("quotient", dif.o_quotient, eq);
      chk("remainder", dif.o_remainder, er);
      chk("dbz", dif.o_divide_by_zero, edbz);
      chk("error", dif.o_error, eerr);
      chk("start_count", starts, (b == 0) ? 0 : 1);
      chk("operands_stable", stable, 1);
      chk("busy_in_op", busy_ok, 1);
      ptr_m = (w + 1) % R;
      if (rr_left[w] > 0) begin
        rr_left[w]--;
        raise(w, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      end
      step();
      chk("valid_pulse", 32'(dif.o_valid), 0);
      chk("error_pulse", dif.o_error, 0);
      chk("hold_q", dif.o_quotient, eq);
      chk("idle_busy", busy, 0);
      pgap = elat + 1;
    end
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1; step(); rst = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int exp_f [4] = '{1, 3, 1, 3};
    dif.i_request = '0; dif.i_dividend = '0; dif.i_divisor = '0;
    clear_all();
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", 32'(dif.o_grant), 0);
    chk("rst_valid", 32'(dif.o_valid), 0);
    chk("rst_q", dif.o_quotient, 0);
    chk("rst_r", dif.o_remainder, 0);
    chk("rst_start", dstart, 0);
    chk("rst_div_dvd", ddvd, 0);
    chk("rst_err", dif.o_error, 0);
    rst = 1'b0;

    // Single operation
    raise(0, 8'd200, 8'd7); serve(-1);
    chk("single_q", dif.o_quotient, 28);
    chk("single_r", dif.o_remainder, 4);

    // Contention from pointer 0
    do_reset(); gseq.delete();
    raise(0, 8'd100, 8'd3); raise(1, 8'd255, 8'd16); raise(2, 8'd17, 8'd17); raise(3, 8'd9, 8'd200);
    serve(-1);
    chk("contention_n", gseq.size(), 4);
    foreach (gseq[i]) chk("contention_order", gseq[i], i);

    // Divide by zero
    raise(2, 8'd55, 8'd0); serve(-1);
    chk("dbz_q_hold", dif.o_quotient, 255);
    chk("dbz_r_hold", dif.o_remainder, 55);

    // Fairness: 1 and 3 keep re-requesting
    do_reset(); gseq.delete();
    rr_left[1] = 1; rr_left[3] = 1;
    raise(1, 8'd77, 8'd5); raise(3, 8'd250, 8'd11);
    serve(-1);
    chk("fair_n", gseq.size(), 4);
    foreach (gseq[i]) if (i < 4) chk("fair_order", gseq[i], exp_f[i]);

    // Timeout with a silent divider
    stub = 1'b1;
    raise(0, 8'd100, 8'd7); serve(-1);
    stub = 1'b0;

    // Request raised and withdrawn while busy gets nothing
    raise(0, 8'd123, 8'd10); serve(2);
    step(); step();
    chk("ghost_grant", 32'(dif.o_grant), 0);
    chk("ghost_busy", busy, 0);

    // Reset in the middle of WAIT
    raise(0, 8'd200, 8'd9);
    #1; begin
      int t = 0;
      while (dif.o_grant == '0 && t < 40) begin step(); t++; end
    end
    chk("mrst_grant", 32'(dif.o_grant), 1);
    step(); clear_all();
    repeat (4) step();
    chk("mrst_busy_pre", busy, 1);
    chk("mrst_valid_pre", 32'(dif.o_valid), 0);
    rst = 1'b1; step();
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", 32'(dif.o_valid), 0);
    chk("mrst_err", dif.o_error, 0);
    chk("mrst_q", dif.o_quotient, 0);
    chk("mrst_start", dstart, 0);
    chk("mrst_div_dvs", ddvs, 0);
    rst = 1'b0; ptr_m = 0;
    raise(3, 8'd91, 8'd13); serve(-1);

    // Random request masks and operands
    for (int bt = 0; bt < 8; bt++) begin
      int mask = $urandom_range(1, 15);
      for (int c = 0; c < R; c++)
        if (mask[c]) raise(c, 8'($urandom_range(0, 255)),
                           ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      serve(-1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
